// File: rtl/beacon_freq_classifier.sv
// IR beacon period classifier: measures rising-edge spacing of ir_in and
// turns a run of MATCH_N equal band classifications into a stable 2-bit code.
// Ports:
//   clock        system clock
//   reset        synchronous active-low reset
//   ir_in        raw asynchronous photodetector input
//   signal       debounced beacon code (00 none, 01/10/11 band 1/2/3)
//   period_out   last measured period in clock cycles
//   period_valid one-cycle strobe when period_out updates
//   locked       high while signal is non-zero
module beacon_freq_classifier #(
  parameter int PERIOD_W = 20,
  parameter int B1_MIN   = 90000,
  parameter int B1_MAX   = 110000,
  parameter int B2_MIN   = 36000,
  parameter int B2_MAX   = 44000,
  parameter int B3_MIN   = 18000,
  parameter int B3_MAX   = 22000,
  parameter int MATCH_N  = 4,
  parameter int TIMEOUT  = 500000
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                ir_in,
  output logic [1:0]          signal,
  output logic [PERIOD_W-1:0] period_out,
  output logic                period_valid,
  output logic                locked
);

  localparam logic [PERIOD_W-1:0] B1L = PERIOD_W'(B1_MIN);
  localparam logic [PERIOD_W-1:0] B1H = PERIOD_W'(B1_MAX);
  localparam logic [PERIOD_W-1:0] B2L = PERIOD_W'(B2_MIN);
  localparam logic [PERIOD_W-1:0] B2H = PERIOD_W'(B2_MAX);
  localparam logic [PERIOD_W-1:0] B3L = PERIOD_W'(B3_MIN);
  localparam logic [PERIOD_W-1:0] B3H = PERIOD_W'(B3_MAX);
  localparam logic [PERIOD_W-1:0] TO  = PERIOD_W'(TIMEOUT);
  localparam logic [PERIOD_W-1:0] ONE = PERIOD_W'(1);
  localparam logic [3:0]          MN  = 4'(MATCH_N);

  typedef enum logic {
    IDLE,
    MEASURE
  } state_t;

  state_t              state;
  logic                sync1;
  logic                sync2;
  logic                sync3;
  logic                rise;
  logic                expire;
  logic [PERIOD_W-1:0] cnt;
  logic [1:0]          cand;
  logic [3:0]          match;
  logic [1:0]          cls;
  logic [1:0]          nxt_cand;
  logic [3:0]          nxt_match;

  always_ff @(posedge clock) begin
    if (!reset) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      sync3 <= 1'b0;
    end else begin
      sync1 <= ir_in;
      sync2 <= sync1;
      sync3 <= sync2;
    end
  end

  assign rise = sync2 & ~sync3;

  // An edge in the same cycle as the timeout wins: the period is captured.
  assign expire = (state == MEASURE) && !rise && (cnt == TO);

  always_comb begin
    cls = 2'b00;
    unique case (1'b1)
      (period_out >= B1L && period_out <= B1H): cls = 2'b01;
      (period_out >= B2L && period_out <= B2H): cls = 2'b10;
      (period_out >= B3L && period_out <= B3H): cls = 2'b11;
      default:                                  cls = 2'b00;
    endcase
  end

  always_comb begin
    nxt_cand  = cls;
    nxt_match = 4'd1;
    if (cls == cand) begin
      nxt_cand  = cand;
      nxt_match = (match >= MN) ? MN : match + 4'd1;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state        <= IDLE;
      cnt          <= '0;
      period_out   <= '0;
      period_valid <= 1'b0;
      cand         <= 2'b00;
      match        <= 4'd0;
      signal       <= 2'b00;
      locked       <= 1'b0;
    end else begin
      period_valid <= 1'b0;
      unique case (state)
        IDLE: begin
          cnt <= '0;
          if (rise) begin
            cnt   <= ONE;
            state <= MEASURE;
          end
        end
        MEASURE: begin
          if (rise) begin
            period_out   <= cnt;
            period_valid <= 1'b1;
            cnt          <= ONE;
          end else if (expire) begin
            cnt   <= '0;
            state <= IDLE;
          end else begin
            cnt <= cnt + ONE;
          end
        end
      endcase
      // Consensus runs one cycle after capture, on the registered period.
      if (expire) begin
        cand   <= 2'b00;
        match  <= 4'd0;
        signal <= 2'b00;
        locked <= 1'b0;
      end else if (period_valid) begin
        cand  <= nxt_cand;
        match <= nxt_match;
        if (nxt_match == MN) begin
          signal <= nxt_cand;
          locked <= (nxt_cand != 2'b00);
        end
      end
    end
  end

endmodule

// File: tb/tb_beacon_freq_classifier.sv
// Directed bench for beacon_freq_classifier with shrunk bands/timeout.
// Each step raises ir_in once and checks strobe, period and code around it.
module tb_beacon_freq_classifier;

  logic       clock;
  logic       reset;
  logic       ir_in;
  logic [1:0] signal;
  logic [9:0] period_out;
  logic       period_valid;
  logic       locked;

  int n_cmp;
  int n_bad;

  beacon_freq_classifier #(
    .PERIOD_W(10),
    .B1_MIN(90), .B1_MAX(110),
    .B2_MIN(36), .B2_MAX(44),
    .B3_MIN(18), .B3_MAX(22),
    .MATCH_N(4),
    .TIMEOUT(500)
  ) dut (
    .clock(clock),
    .reset(reset),
    .ir_in(ir_in),
    .signal(signal),
    .period_out(period_out),
    .period_valid(period_valid),
    .locked(locked)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Raise ir_in now; the next step starts len cycles later.
  // The rising edge reports the gap since the previous step's rise.
  task automatic step(input int len, input bit pv, input int per,
                      input logic [1:0] s_old, input logic [1:0] s_new);
    ir_in = 1'b1;
    repeat (3) @(negedge clock);
    chk("pv", 32'(period_valid), 32'(pv));
    if (pv) chk("period", 32'(period_out), 32'(per));
    chk("sig_before", 32'(signal), 32'(s_old));
    chk("lock_before", 32'(locked), 32'(s_old != 2'b00));
    @(negedge clock);
    chk("pv_drop", 32'(period_valid), 32'd0);
    chk("sig_after", 32'(signal), 32'(s_new));
    chk("lock_after", 32'(locked), 32'(s_new != 2'b00));
    repeat (len / 2 - 4) @(negedge clock);
    ir_in = 1'b0;
    repeat (len - len / 2) @(negedge clock);
  endtask

  initial begin
    int nz;
    n_cmp = 0;
    n_bad = 0;
    reset = 1'b0;
    ir_in = 1'b0;
    repeat (3) @(negedge clock);
    chk("rst_sig", 32'(signal), 32'd0);
    chk("rst_period", 32'(period_out), 32'd0);
    chk("rst_pv", 32'(period_valid), 32'd0);
    chk("rst_lock", 32'(locked), 32'd0);
    reset = 1'b1;

    nz = 0;
    repeat (1000) begin
      @(negedge clock);
      if (signal != 0 || period_out != 0 || period_valid || locked) nz++;
    end
    chk("idle_quiet", 32'(nz), 32'd0);

    // band 1 lock, switch to band 2, broken band-3 runs, band 3, out of band
    step(100, 0,   0, 2'd0, 2'd0);
    step(100, 1, 100, 2'd0, 2'd0);
    step(100, 1, 100, 2'd0, 2'd0);
    step(100, 1, 100, 2'd0, 2'd0);
    step( 40, 1, 100, 2'd0, 2'd1);
    step( 40, 1,  40, 2'd1, 2'd1);
    step( 40, 1,  40, 2'd1, 2'd1);
    step( 40, 1,  40, 2'd1, 2'd1);
    step( 20, 1,  40, 2'd1, 2'd2);
    step( 20, 1,  20, 2'd2, 2'd2);
    step( 20, 1,  20, 2'd2, 2'd2);
    step( 40, 1,  20, 2'd2, 2'd2);
    step( 20, 1,  40, 2'd2, 2'd2);
    step( 20, 1,  20, 2'd2, 2'd2);
    step( 20, 1,  20, 2'd2, 2'd2);
    step( 20, 1,  20, 2'd2, 2'd2);
    step( 60, 1,  20, 2'd2, 2'd3);
    step( 60, 1,  60, 2'd3, 2'd3);
    step( 60, 1,  60, 2'd3, 2'd3);
    step( 60, 1,  60, 2'd3, 2'd3);
    step(100, 1,  60, 2'd3, 2'd0);
    step( 20, 1, 100, 2'd0, 2'd0);
    step( 20, 1,  20, 2'd0, 2'd0);
    step( 20, 1,  20, 2'd0, 2'd0);
    step( 20, 1,  20, 2'd0, 2'd0);
    step( 20, 1,  20, 2'd0, 2'd3);

    // tone stops: 20 cycles already spent since the last rise
    repeat (482) @(negedge clock);
    chk("to_hold", 32'(signal), 32'd3);
    @(negedge clock);
    chk("to_sig", 32'(signal), 32'd0);
    chk("to_lock", 32'(locked), 32'd0);

    // first edge after timeout: no period; next edge hits counter = 500
    step(500, 0,   0, 2'd0, 2'd0);
    step(100, 1, 500, 2'd0, 2'd0);
    step(100, 1, 100, 2'd0, 2'd0);
    step(100, 1, 100, 2'd0, 2'd0);
    step(100, 1, 100, 2'd0, 2'd0);
    step(100, 1, 100, 2'd0, 2'd1);

    reset = 1'b0;
    @(negedge clock);
    reset = 1'b1;
    chk("mid_rst_sig", 32'(signal), 32'd0);
    chk("mid_rst_period", 32'(period_out), 32'd0);
    chk("mid_rst_pv", 32'(period_valid), 32'd0);
    chk("mid_rst_lock", 32'(locked), 32'd0);

    step(100, 0,   0, 2'd0, 2'd0);
    step(100, 1, 100, 2'd0, 2'd0);
    step(100, 1, 100, 2'd0, 2'd0);
    step(100, 1, 100, 2'd0, 2'd0);
    step(100, 1, 100, 2'd0, 2'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/beacon_freq_classifier.md
# beacon_freq_classifier

Measures the period of one raw IR-beacon photodetector input and classifies it into a 2-bit beacon code. Stable codes feed the aiming/firing servo stage and the 7-segment status display. One instance sits directly upstream of those consumers per sensor (forward, left, right). It replaces ad-hoc edge counting with a debounced, timeout-protected period classifier.

## Interface
Parameters:
- PERIOD_W, 20, width of the period counter and of `period_out`
- B1_MIN, 90000, lower period bound for code 01 (cycles, inclusive; ≈1 kHz at 100 MHz)
- B1_MAX, 110000, upper period bound for code 01 (inclusive)
- B2_MIN, 36000, lower bound for code 10 (inclusive; ≈2.5 kHz)
- B2_MAX, 44000, upper bound for code 10 (inclusive)
- B3_MIN, 18000, lower bound for code 11 (inclusive; ≈5 kHz)
- B3_MAX, 22000, upper bound for code 11 (inclusive)
- MATCH_N, 4, consecutive equal classifications required before `signal` changes (1..15)
- TIMEOUT, 500000, cycles without a rising edge before the beacon is declared lost (< 2^PERIOD_W)

Bands must not overlap; checking this is the integrator's responsibility.

Ports:
- clock  in  1  system clock (100 MHz)
- reset  in  1  synchronous, active-low reset
- ir_in  in  1  raw, asynchronous detector input
- signal  out  2  debounced beacon code: 00 none, 01 band 1, 10 band 2, 11 band 3
- period_out  out  PERIOD_W  last measured period in cycles
- period_valid  out  1  one-cycle strobe when `period_out` updates
- locked  out  1  high while `signal` ≠ 00

## Operation
- `ir_in` passes through a 2-flop synchronizer. A third flop provides rising-edge detection. `edge` is a 1-cycle internal strobe.
- The state machine has two states: IDLE and MEASURE.
  - IDLE: the counter is held at 0. On `edge`, the counter is set to 1 and the state goes to MEASURE. No period is produced by this first edge.
  - MEASURE, no `edge` this cycle: the counter increments.
  - MEASURE, `edge` this cycle: capture the counter value as the period, reload the counter to 1, and stay in MEASURE.
  - MEASURE, counter reaches TIMEOUT before an edge: go to IDLE. `signal` is set to 00, the candidate is cleared to 00, and the match count is cleared to 0.
- Period definition: the distance in clock cycles between two successive `edge` strobes.
- Classification of a captured period p:
  - 01 if B1_MIN ≤ p ≤ B1_MAX.
  - 10 if p is in the band-2 range.
  - 11 if p is in the band-3 range.
  - 00 otherwise.
- Consensus:
  - If the class equals `candidate`, the match count increments, saturating at MATCH_N.
  - Otherwise, `candidate` is set to the class and the match count is set to 1.
  - When the match count equals MATCH_N, `signal` is set to `candidate`.
  - A persistent out-of-band period therefore drives `signal` to 00 after MATCH_N periods.
- `locked` = (`signal` ≠ 00), registered alongside `signal`.
- Simultaneous edge and TIMEOUT in the same cycle: the edge wins. The period equals TIMEOUT and is classified normally.

## Timing
- Reset values: `signal` = 00, `period_out` = 0, `period_valid` = 0, `locked` = 0. Internally: state IDLE, counter 0, candidate 00, match count 0.
- Reset asserted mid-measurement clears everything on the next clock edge. The first edge after release starts a fresh measurement.
- Edge latency: a rising edge on `ir_in` that is stable before clock edge k produces `edge` in cycle k+2.
- In the same cycle as `edge` (relative to that `edge`):
  - `period_out` and `period_valid` are registered in the next cycle (+1).
  - Classification and the consensus update use the captured period at +1.
  - `signal` and `locked` change at +2.
- After a clean band-1 tone starts:
  - The first period is reported at the second detected edge.
  - `signal` becomes 01 two cycles after the (MATCH_N+1)-th detected edge.
- Timeout: `signal` drops to 00 exactly TIMEOUT cycles after the last `edge`.
- The counter never wraps. TIMEOUT bounds it below 2^PERIOD_W.

## Test plan
The bench overrides parameters: B1 = 90..110, B2 = 36..44, B3 = 18..22, MATCH_N = 4, TIMEOUT = 500, PERIOD_W = 10.
- Reset and no input: hold `ir_in` at 0 for 1000 cycles. All outputs stay 0.
- Band-1 tone, period 100:
  - `period_valid` pulses every 100 cycles with `period_out` = 100.
  - `signal` goes 00→01 and `locked` goes 1, both two cycles after the 5th detected edge.
- Band switch from period 100 to period 40:
  - `signal` stays 01 through the first 3 periods of 40.
  - `signal` becomes 10 after the 4th.
  - A single period of 20 inserted mid-stream resets consensus without changing `signal`.
- Out of band and timeout:
  - Locked at 11 (period 20), then switch to period 60. `signal` goes to 00 after 4 periods.
  - Separately, while locked, stop toggling `ir_in`. `signal` goes to 00 exactly 500 cycles after the last edge, and the next edge produces no `period_valid`.
- Edge/timeout collision and reset mid-operation:
  - An edge landing exactly at counter = 500 yields `period_out` = 500 and class 00, with no drop to IDLE.
  - Asserting `reset` low for 1 cycle while locked zeroes all outputs on the next cycle; relock then requires 5 fresh edges.
